// File: rtl/mmio_host_requester.sv
// rtl/mmio_host_requester.sv - host-side CCI-P MMIO initiator: one command at a time, tid-matched read responses with timeout
module mmio_host_requester #(
   parameter int TID_W          = 9,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [15:0]      cmd_addr,
   input  logic [63:0]      cmd_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [63:0]      rsp_data,
   output logic             rsp_timeout,
   output logic             mmio_wr_valid,
   output logic             mmio_rd_valid,
   output logic [15:0]      mmio_addr,
   output logic [TID_W-1:0] mmio_tid,
   output logic [63:0]      mmio_data,
   input  logic             mmio_rsp_valid,
   input  logic [TID_W-1:0] mmio_rsp_tid,
   input  logic [63:0]      mmio_rsp_data,
   output logic             err_stray
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR      = 3'd1;
   localparam logic [2:0] S_RD_REQ  = 3'd2;
   localparam logic [2:0] S_RD_WAIT = 3'd3;
   localparam logic [2:0] S_RSP     = 3'd4;

   logic [2:0]       r_state;
   logic [TID_W-1:0] r_tid;
   logic [CNT_W-1:0] r_cnt;

   logic w_accept;
   logic w_match;
   logic w_expire;

   assign cmd_ready = (r_state == S_IDLE);
   assign w_accept  = cmd_valid & cmd_ready;
   // mmio_tid still holds the tid issued with the outstanding read.
   assign w_match   = mmio_rsp_valid && (mmio_rsp_tid == mmio_tid);
   // The counter is about to reach TIMEOUT_CYCLES-1, so rsp_valid rises
   // exactly TIMEOUT_CYCLES cycles after the read strobe.
   assign w_expire  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 2));

   // Command sequencer: strobes, tid/timeout counters and the response register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_tid         <= '0;
         r_cnt         <= '0;
         mmio_wr_valid <= 1'b0;
         mmio_rd_valid <= 1'b0;
         mmio_addr     <= '0;
         mmio_tid      <= '0;
         mmio_data     <= '0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         rsp_timeout   <= 1'b0;
      end else begin
         mmio_wr_valid <= 1'b0;
         mmio_rd_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  mmio_addr <= cmd_addr;
                  mmio_tid  <= r_tid;
                  if (cmd_write) begin
                     mmio_data     <= cmd_wdata;
                     mmio_wr_valid <= 1'b1;
                     r_state       <= S_WR;
                  end else begin
                     mmio_rd_valid <= 1'b1;
                     r_state       <= S_RD_REQ;
                  end
               end
            end
            S_WR: begin
               r_state <= S_IDLE;
            end
            S_RD_REQ: begin
               r_cnt   <= '0;
               r_tid   <= r_tid + TID_W'(1);
               r_state <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               r_cnt <= r_cnt + CNT_W'(1);
               // A matching response beats a simultaneous timeout.
               if (w_match) begin
                  rsp_data    <= mmio_rsp_data;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  r_state     <= S_RSP;
               end else if (w_expire) begin
                  rsp_data    <= '0;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  r_state     <= S_RSP;
               end
            end
            S_RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Sticky flag for any response that does not answer the outstanding read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_stray <= 1'b0;
      end else if (mmio_rsp_valid && !((r_state == S_RD_WAIT) && w_match)) begin
         err_stray <= 1'b1;
      end
   end

endmodule
